grant_arbiter_8: RTL

GRANT_ARBITER_8 -- requirements
Module: grant_arbiter_8

---
 rtl/grant_arbiter_8.sv | 106 ++++++++++
 1 files changed

// File: rtl/grant_arbiter_8.sv
// Eight-way round-robin grant arbiter with hold-time limit and optional
// one-cycle dead time between consecutive grants.
module grant_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 255,
    parameter bit          GAP_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold;
    logic       found;
    logic [2:0] pick_idx;
    logic [2:0] idx;
    logic       hit_lim;
    logic       rel;

    // ptr itself is searched last, so the last holder has lowest priority
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr;
        idx      = ptr;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found    = 1'b1;
                pick_idx = idx;
            end
        end
    end

    assign hit_lim = (hold == HOLD_LIM);
    assign rel     = done || !req[grant_idx] || hit_lim;
    assign busy    = |grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 8'h00;
            grant_idx <= 3'd0;
            ptr       <= 3'd7;
            hold      <= 8'd0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE, GAP: begin
                    if (found) begin
                        state     <= BUSY;
                        grant     <= 8'(1) << pick_idx;
                        grant_idx <= pick_idx;
                        ptr       <= pick_idx;
                        hold      <= 8'd1;
                    end else begin
                        state     <= IDLE;
                        grant     <= 8'h00;
                        grant_idx <= 3'd0;
                        hold      <= 8'd0;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        timeout <= !done && req[grant_idx] && hit_lim;
                        if (!GAP_EN && found) begin
                            state     <= BUSY;
                            grant     <= 8'(1) << pick_idx;
                            grant_idx <= pick_idx;
                            ptr       <= pick_idx;
                            hold      <= 8'd1;
                        end else begin
                            state     <= GAP_EN ? GAP : IDLE;
                            grant     <= 8'h00;
                            grant_idx <= 3'd0;
                            hold      <= 8'd0;
                        end
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= 8'h00;
                    grant_idx <= 3'd0;
                    hold      <= 8'd0;
                end
            endcase
        end
    end

endmodule
